// File: rtl/hwag_coil_sched_if.sv
// hwag_coil_sched_if
// Bundles the angle input, the shadow-register write port and the coil
// outputs of the coil scheduler.
//   master : drives hwag_run, acnt, cfg_we/cfg_ch/cfg_sel/cfg_data;
//            receives cfg_err, cfg_pending, coil_out
//   slave  : the scheduler side (directions mirrored)
interface hwag_coil_sched_if #(
  parameter int CH_NUM      = 4,
  parameter int ANGLE_WIDTH = 24
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                   hwag_run;
  logic [ANGLE_WIDTH-1:0] acnt;
  logic                   cfg_we;
  logic [CH_W-1:0]        cfg_ch;
  logic                   cfg_sel;
  logic [ANGLE_WIDTH-1:0] cfg_data;
  logic                   cfg_err;
  logic                   cfg_pending;
  logic [CH_NUM-1:0]      coil_out;

  modport master (
    output hwag_run, acnt, cfg_we, cfg_ch, cfg_sel, cfg_data,
    input  cfg_err, cfg_pending, coil_out
  );

  modport slave (
    input  hwag_run, acnt, cfg_we, cfg_ch, cfg_sel, cfg_data,
    output cfg_err, cfg_pending, coil_out
  );
endinterface

// File: rtl/hwag_coil_sched.sv
// hwag_coil_sched
// Round-robin coil scheduler: one window comparator is shared across CH_NUM
// channels, comparing the angle count against per-channel set/reset angles.
// Angle writes go to shadow registers and are committed to the active set
// at the angle wrap (or continuously while the angle path is not running).
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : hwag_coil_sched_if.slave (hwag_run, acnt, cfg_*, coil_out)
// Optional feature macro: HWAG_COIL_SCHED_DWELL_LIMIT_EN adds a per-channel
// dwell counter that cuts the coil after DWELL_MAX clocks of on-time.
//
// state   | meaning
// ST_IDLE | angle path not synchronised; coils off, scan index at 0
// ST_SCAN | evaluating one channel per cycle, index advancing mod CH_NUM
module hwag_coil_sched #(
  parameter int                     CH_NUM      = 4,
  parameter int                     ANGLE_WIDTH = 24,
  parameter logic [ANGLE_WIDTH-1:0] MAX_ANGLE   = ANGLE_WIDTH'(3839),
  parameter int unsigned            DWELL_MAX   = 2000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  hwag_coil_sched_if.slave   bus
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CH_W-1:0]        r_idx, w_idx_nxt;
  logic [CH_NUM-1:0]      r_coil, w_coil_nxt;
  logic                   r_err, r_pend;
  logic [ANGLE_WIDTH-1:0] r_acnt_prev;
  logic [ANGLE_WIDTH-1:0] r_set_sh  [CH_NUM];
  logic [ANGLE_WIDTH-1:0] r_rst_sh  [CH_NUM];
  logic [ANGLE_WIDTH-1:0] r_set_act [CH_NUM];
  logic [ANGLE_WIDTH-1:0] r_rst_act [CH_NUM];

  logic                   w_wrap, w_commit, w_wr_ok, w_on, w_on_eff;
  logic [ANGLE_WIDTH-1:0] w_set, w_rst;
  logic [CH_NUM-1:0]      w_force;

  // Loss of sync is a commit point of its own, never a wrap.
  assign w_wrap   = bus.hwag_run && (bus.acnt < r_acnt_prev);
  assign w_commit = w_wrap || !bus.hwag_run;
  assign w_wr_ok  = bus.cfg_we && (bus.cfg_data <= MAX_ANGLE) &&
                    ({1'b0, bus.cfg_ch} < (CH_W+1)'(CH_NUM));

  assign w_set = r_set_act[r_idx];
  assign w_rst = r_rst_act[r_idx];

  always_comb begin
    w_on = 1'b0;
    if (w_set < w_rst)
      w_on = (bus.acnt >= w_set) && (bus.acnt < w_rst);
    else if (w_set > w_rst)
      w_on = (bus.acnt >= w_set) || (bus.acnt < w_rst);
  end

`ifdef HWAG_COIL_SCHED_DWELL_LIMIT_EN
  localparam int DW = $clog2(DWELL_MAX + 1);

  logic [DW-1:0]     r_dwell [CH_NUM];
  logic [CH_NUM-1:0] r_lim;
  logic [CH_NUM-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < CH_NUM; i++)
      w_hit[i] = r_coil[i] && (r_dwell[i] == DW'(DWELL_MAX));
  end

  // A limited channel stays dark until the scan sees the window closed.
  assign w_on_eff = w_on && !r_lim[r_idx];
  assign w_force  = w_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lim <= '0;
      for (int i = 0; i < CH_NUM; i++) r_dwell[i] <= '0;
    end else if (r_state != ST_SCAN || !bus.hwag_run) begin
      r_lim <= '0;
      for (int i = 0; i < CH_NUM; i++) r_dwell[i] <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (r_idx == CH_W'(i) && !w_on) begin
          r_lim[i]   <= 1'b0;
          r_dwell[i] <= '0;
        end else begin
          if (w_hit[i]) r_lim[i] <= 1'b1;
          if (r_coil[i] && !w_hit[i]) r_dwell[i] <= r_dwell[i] + 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_dwell;
  assign w_unused_dwell = (DWELL_MAX == 0);
  assign w_on_eff       = w_on;
  assign w_force        = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_coil_nxt  = r_coil;
    case (r_state)
      ST_IDLE: begin
        w_coil_nxt = '0;
        w_idx_nxt  = '0;
        if (bus.hwag_run) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (!bus.hwag_run) begin
          w_state_nxt = ST_IDLE;
          w_coil_nxt  = '0;
          w_idx_nxt   = '0;
        end else begin
          w_coil_nxt[r_idx] = w_on_eff;
          w_idx_nxt = (r_idx == CH_W'(CH_NUM - 1)) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_coil_nxt  = '0;
        w_idx_nxt   = '0;
      end
    endcase
    w_coil_nxt = w_coil_nxt & ~w_force;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_coil  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_coil  <= w_coil_nxt;
    end
  end

  // A write coinciding with a commit: the commit takes the old shadow and
  // the new word stays pending for the next commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acnt_prev <= '0;
      r_err       <= 1'b0;
      r_pend      <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_set_sh[i]  <= '0;
        r_rst_sh[i]  <= '0;
        r_set_act[i] <= '0;
        r_rst_act[i] <= '0;
      end
    end else begin
      r_acnt_prev <= bus.acnt;
      r_err       <= bus.cfg_we && !w_wr_ok;
      if (w_commit) begin
        for (int i = 0; i < CH_NUM; i++) begin
          r_set_act[i] <= r_set_sh[i];
          r_rst_act[i] <= r_rst_sh[i];
        end
      end
      if (w_wr_ok) begin
        if (bus.cfg_sel) r_rst_sh[bus.cfg_ch] <= bus.cfg_data;
        else             r_set_sh[bus.cfg_ch] <= bus.cfg_data;
        r_pend <= 1'b1;
      end else if (w_commit) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign bus.cfg_err     = r_err;
  assign bus.cfg_pending = r_pend;
  assign bus.coil_out    = r_coil;
endmodule

// File: doc/hwag_coil_sched.md
# hwag_coil_sched

Multi-channel coil scheduler for the HWAG angle path. It shares one window comparator round-robin across CH_NUM ignition channels, comparing the synchronised angle counter against per-channel set/reset angles. It drives one registered coil output per channel. It sits downstream of the slave angle counters and replaces the fixed set/reset compare pair. Angle configuration is written into shadow registers and committed atomically at the angle wrap, so a channel never sees a half-updated window.

## Interface
Parameters:
- CH_NUM, 4, number of coil channels (2..8)
- ANGLE_WIDTH, 24, angle counter width
- MAX_ANGLE, 24'd3839, last valid angle count; the count wraps to 0 after it
- DWELL_MAX, 24'd2000000, maximum coil on-time in clk cycles (used only with HWAG_COIL_SCHED_DWELL_LIMIT_EN)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- hwag_run  in  1  angle path synchronised (hwag_start)
- acnt  in  ANGLE_WIDTH  current angle count
- cfg_we  in  1  single-cycle shadow write strobe
- cfg_ch  in  $clog2(CH_NUM)  target channel
- cfg_sel  in  1  0 = set angle, 1 = reset angle
- cfg_data  in  ANGLE_WIDTH  angle value
- cfg_err  out  1  one-cycle pulse: write rejected
- cfg_pending  out  1  shadow holds uncommitted data
- coil_out  out  CH_NUM  coil drive, 1 = charging

## Operation
- Storage: set_sh/rst_sh (shadow) and set_act/rst_act (active) per channel. All reset to 0.
- Write: on cfg_we with cfg_data ≤ MAX_ANGLE and cfg_ch < CH_NUM, the selected shadow word is written and cfg_pending is set. Otherwise nothing is written and cfg_err pulses.
- Wrap detect: acnt_prev is registered each cycle. wrap = hwag_run & (acnt < acnt_prev).
- Commit: every shadow word is copied to active, and cfg_pending clears:
  - on wrap, or
  - every cycle while hwag_run = 0.
- Commit and cfg_we in the same cycle: the commit copies the old shadow. The new write lands in shadow, and cfg_pending stays 1.
- FSM IDLE:
  - Entered on reset or when hwag_run = 0.
  - coil_out = 0; scan index = 0.
  - Moves to SCAN on the cycle after hwag_run rises.
- FSM SCAN:
  - Each cycle, channel idx is evaluated against acnt with its active window. idx then advances modulo CH_NUM.
  - If set < rst: on = (acnt ≥ set) & (acnt < rst).
  - If set > rst (window spans the wrap): on = (acnt ≥ set) | (acnt < rst).
  - If set == rst: on = 0 (channel disabled).
  - coil_out[idx] takes the result; other bits hold.
- hwag_run falling while in SCAN: all coil_out clear on the next edge, and the FSM returns to IDLE. The loss of sync is never treated as a wrap.
- Comparisons are unsigned, full ANGLE_WIDTH.

## Timing
- Reset: coil_out = 0, cfg_err = 0, cfg_pending = 0, FSM = IDLE, idx = 0, acnt_prev = 0.
- Update latency: coil_out[i] reflects a new acnt value within CH_NUM+1 cycles. Each channel is revisited every CH_NUM cycles.
- acnt must hold each value at least CH_NUM cycles; at one angle step per ≥ CH_NUM clocks, no window edge is missed.
- cfg_err asserts 1 cycle after the offending cfg_we.
- cfg_pending sets 1 cycle after cfg_we.
- A committed window takes effect at the first scan of each channel after the wrap cycle.

## Configuration
- HWAG_COIL_SCHED_DWELL_LIMIT_EN defined:
  - Each channel has a dwell counter that counts clk cycles while coil_out[i] = 1.
  - When the counter reaches DWELL_MAX, coil_out[i] is forced to 0 and the channel latches "limited".
  - The latch clears, and the counter resets, the first time the scan evaluates on = 0 for that channel. The coil cannot re-energise within the same window.
- Undefined: no counters or latches exist; coil on-time is set by the window only.

## Test plan
- Reset mid-SCAN with coil_out = 4'b0101 -> rst low: coil_out = 0 immediately (asynchronous); after release, FSM is IDLE and idx = 0.
- hwag_run = 0; write ch0 set = 32, rst = 96 -> cfg_pending pulses and clears next cycle (immediate commit). Then run with acnt stepping every 8 clk from 0 -> coil_out[0] high from acnt 32 to 95, low at 96 within 5 clk.
- Wrap window ch1 set = 3800, rst = 40 -> coil_out[1] high for acnt 3800..3839 and 0..39, low elsewhere.
- While running with ch2 = (100,200): write ch2 (500,600) at acnt = 150 -> coil_out[2] keeps the old window until acnt wraps 3839 -> 0; then the new window applies and cfg_pending clears.
- cfg_data = 3840 -> cfg_err pulses 1 cycle; shadow unchanged; cfg_pending unchanged.
- With HWAG_COIL_SCHED_DWELL_LIMIT_EN and DWELL_MAX = 100: window held open 500 clk -> coil_out drops after 100 clk, stays low through the window, and re-energises in the next revolution's window.
